// File: rtl/icache_line_fill.sv
// icache_line_fill
// Refill engine between the instruction cache miss port and the narrow
// instruction-memory bus. A line-fill request is accepted from IDLE, one bus
// read is issued per 32-bit word with up to MAX_OUTSTANDING reads in flight,
// the in-order responses are assembled into the full line, and the line is
// handed back with a one-cycle line_valid pulse.
//
// Optional feature macro: ICACHE_FILL_WRAP_EN
//   defined   : critical-word-first. The fill starts at the word addressed by
//               fill_addr and wraps within the line; first_word_valid pulses
//               the cycle after the first response has been captured.
//   undefined : the fill always starts at word 0, fill_addr low bits are
//               ignored and there is no first_word_valid port.
//
// Ports:
//   clk              clock
//   rst              synchronous active-high reset
//   fill_req         level request (cache mem_read)
//   fill_addr        line address (cache mem_addr)
//   line_data        assembled line, word k at bits [k*32 +: 32]
//   line_valid       one-cycle pulse, line_data valid
//   bus_req_valid    read request valid (registered)
//   bus_req_ready    memory accepts request
//   bus_req_addr     word-aligned read address (registered)
//   bus_rsp_valid    read data valid, responses in request order
//   bus_rsp_data     read data
//   first_word_valid (ICACHE_FILL_WRAP_EN only) critical word captured
//   busy             high in every state except IDLE
//
// BUS_WIDTH is the instruction width (32); LINE_SIZE_BYTES must be a power
// of two >= 8 and MAX_OUTSTANDING must lie in 1..BEATS.
module icache_line_fill #(
    parameter int LINE_SIZE_BYTES = 64,
    parameter int BUS_WIDTH       = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fill_req,
    input  logic [ADDR_WIDTH-1:0]        fill_addr,
    output logic [LINE_SIZE_BYTES*8-1:0] line_data,
    output logic                         line_valid,
    output logic                         bus_req_valid,
    input  logic                         bus_req_ready,
    output logic [ADDR_WIDTH-1:0]        bus_req_addr,
    input  logic                         bus_rsp_valid,
    input  logic [BUS_WIDTH-1:0]         bus_rsp_data,
`ifdef ICACHE_FILL_WRAP_EN
    output logic                         first_word_valid,
`endif
    output logic                         busy
);

    localparam int BEATS       = LINE_SIZE_BYTES * 8 / BUS_WIDTH;
    localparam int OFFSET_BITS = $clog2(LINE_SIZE_BYTES);
    localparam int WORD_SHIFT  = $clog2(BUS_WIDTH / 8);
    localparam int IDX_BITS    = $clog2(BEATS);
    localparam int CW          = IDX_BITS + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DONE  = 2'd2,
        REARM = 2'd3
    } state_t;

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [IDX_BITS-1:0]   start_r;
    logic [CW-1:0]         iss_cnt_r;
    logic [CW-1:0]         rsp_cnt_r;

    logic [ADDR_WIDTH-1:0] acc_base_s;
    logic [IDX_BITS-1:0]   acc_start_s;
    logic                  issue_fire_s;
    logic [CW-1:0]         iss_next_s;
    logic [CW-1:0]         rsp_next_s;
    logic [CW-1:0]         out_next_s;
    logic                  issue_ok_s;
    logic [ADDR_WIDTH-1:0] next_addr_s;
    logic                  last_rsp_s;

    // Beat n of a fill lands on word (start + n) mod BEATS; the counter's
    // extra top bit is dropped so the index wraps inside the line.
    function automatic logic [IDX_BITS-1:0] word_index(input logic [IDX_BITS-1:0] start,
                                                       input logic [CW-1:0]       n);
        return start + n[IDX_BITS-1:0];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [IDX_BITS-1:0]   idx);
        return base + (ADDR_WIDTH'(idx) << WORD_SHIFT);
    endfunction

    // Next-cycle counter view used to register the issue decision.
    always_comb begin
        acc_base_s   = fill_addr & ~ADDR_WIDTH'(LINE_SIZE_BYTES - 1);
`ifdef ICACHE_FILL_WRAP_EN
        acc_start_s  = fill_addr[OFFSET_BITS-1:WORD_SHIFT];
`else
        acc_start_s  = {IDX_BITS{1'b0}};
`endif
        issue_fire_s = bus_req_valid & bus_req_ready;
        iss_next_s   = iss_cnt_r + {{(CW-1){1'b0}}, issue_fire_s};
        rsp_next_s   = rsp_cnt_r + {{(CW-1){1'b0}}, bus_rsp_valid};
        out_next_s   = iss_next_s - rsp_next_s;
        // Because the request is registered, the limit is checked against the
        // counts as they will be after this edge; a stalled request therefore
        // keeps its valid and its address until it is accepted.
        issue_ok_s   = (iss_next_s < CW'(BEATS)) && (out_next_s < CW'(MAX_OUTSTANDING));
        next_addr_s  = word_addr(base_r, word_index(start_r, iss_next_s));
        last_rsp_s   = bus_rsp_valid && (rsp_cnt_r == CW'(BEATS - 1));
    end

    // Fill FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= IDLE;
            base_r           <= {ADDR_WIDTH{1'b0}};
            start_r          <= {IDX_BITS{1'b0}};
            iss_cnt_r        <= {CW{1'b0}};
            rsp_cnt_r        <= {CW{1'b0}};
            line_data        <= {(LINE_SIZE_BYTES*8){1'b0}};
            line_valid       <= 1'b0;
            bus_req_valid    <= 1'b0;
            bus_req_addr     <= {ADDR_WIDTH{1'b0}};
            busy             <= 1'b0;
`ifdef ICACHE_FILL_WRAP_EN
            first_word_valid <= 1'b0;
`endif
        end else begin
            line_valid       <= 1'b0;
`ifdef ICACHE_FILL_WRAP_EN
            first_word_valid <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    // Bus responses seen here belong to an abandoned fill.
                    if (fill_req) begin
                        base_r        <= acc_base_s;
                        start_r       <= acc_start_s;
                        iss_cnt_r     <= {CW{1'b0}};
                        rsp_cnt_r     <= {CW{1'b0}};
                        bus_req_valid <= 1'b1;
                        bus_req_addr  <= word_addr(acc_base_s, acc_start_s);
                        busy          <= 1'b1;
                        state_r       <= FILL;
                    end
                end
                FILL: begin
                    iss_cnt_r <= iss_next_s;
                    if (bus_rsp_valid) begin
                        line_data[int'(word_index(start_r, rsp_cnt_r)) * BUS_WIDTH +: BUS_WIDTH]
                            <= bus_rsp_data;
                        rsp_cnt_r <= rsp_next_s;
                    end
`ifdef ICACHE_FILL_WRAP_EN
                    first_word_valid <= bus_rsp_valid && (rsp_cnt_r == {CW{1'b0}});
`endif
                    if (last_rsp_s) begin
                        bus_req_valid <= 1'b0;
                        line_valid    <= 1'b1;
                        state_r       <= DONE;
                    end else begin
                        bus_req_valid <= issue_ok_s;
                        if (issue_ok_s) begin
                            bus_req_addr <= next_addr_s;
                        end
                    end
                end
                DONE: begin
                    state_r <= REARM;
                end
                REARM: begin
                    // The request level from the finished fill must drop
                    // before another fill may be accepted.
                    if (!fill_req) begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    bus_req_valid <= 1'b0;
                    busy          <= 1'b0;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_line_fill.sv
`timescale 1ns/1ps
module tb_icache_line_fill;

    localparam int          NB    = 16;
    localparam logic [31:0] XMASK = 32'hA5A5_0000;
    localparam logic [31:0] LMASK = 32'hFFFF_FFC0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         fill_req      [2];
    logic [31:0]  fill_addr     [2];
    logic [511:0] line_data     [2];
    logic         line_valid    [2];
    logic         bus_req_valid [2];
    logic         bus_req_ready [2];
    logic [31:0]  bus_req_addr  [2];
    logic         bus_rsp_valid [2];
    logic [31:0]  bus_rsp_data  [2];
    logic         busy          [2];
`ifdef ICACHE_FILL_WRAP_EN
    logic         first_word_valid [2];
`endif

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory behaviour knobs (written by the tasks only).
    int lat_a       [2];
    int ready_mode  [2];
    int stall_until [2];

    // Per-fill observations (written by the monitors only).
    int           acc_total [2];
    int           acc_edge  [2];
    int           iss_seen  [2];
    int           rsp_seen  [2];
    int           max_out   [2];
    int           addr_bad  [2];
    int           stall_bad [2];
    int           lv_cnt    [2];
    int           lv_total  [2];
    int           lv_edge   [2];
    int           fwv_cnt   [2];
    int           fwv_edge  [2];
    int           frsp_edge [2];
    logic [511:0] lv_line   [2];
    logic [31:0]  first_addr[2];
    logic [31:0]  exp_base  [2];
    int           exp_start [2];

    int total = 0;
    int bad   = 0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        icache_line_fill #(.MAX_OUTSTANDING(gi == 0 ? 4 : 1)) u_dut (
            .clk              (clk),
            .rst              (rst),
            .fill_req         (fill_req[gi]),
            .fill_addr        (fill_addr[gi]),
            .line_data        (line_data[gi]),
            .line_valid       (line_valid[gi]),
            .bus_req_valid    (bus_req_valid[gi]),
            .bus_req_ready    (bus_req_ready[gi]),
            .bus_req_addr     (bus_req_addr[gi]),
            .bus_rsp_valid    (bus_rsp_valid[gi]),
            .bus_rsp_data     (bus_rsp_data[gi]),
`ifdef ICACHE_FILL_WRAP_EN
            .first_word_valid (first_word_valid[gi]),
`endif
            .busy             (busy[gi])
        );

        int          due_q [$];
        logic [31:0] dat_q [$];
        logic        prev_stall = 1'b0;
        logic [31:0] prev_addr  = 32'h0;
        int          e_l;

        // Memory bookkeeping and protocol monitor, sampling pre-edge values.
        always @(posedge clk) begin
            e_l = cyc + 1;
            if (bus_rsp_valid[gi] === 1'b1 && due_q.size() > 0) begin
                void'(due_q.pop_front());
                void'(dat_q.pop_front());
            end
            if (bus_req_valid[gi] === 1'b1 && bus_req_ready[gi] === 1'b1) begin
                due_q.push_back(e_l + lat_a[gi]);
                dat_q.push_back(bus_req_addr[gi] ^ XMASK);
            end
            if (rst === 1'b0) begin
                if (fill_req[gi] === 1'b1 && busy[gi] === 1'b0) begin
                    acc_total[gi]++;
                    acc_edge[gi]  = e_l;
                    exp_base[gi]  = fill_addr[gi] & LMASK;
`ifdef ICACHE_FILL_WRAP_EN
                    exp_start[gi] = int'(fill_addr[gi][5:2]);
`else
                    exp_start[gi] = 0;
`endif
                    iss_seen[gi]  = 0;
                    rsp_seen[gi]  = 0;
                    max_out[gi]   = 0;
                    addr_bad[gi]  = 0;
                    stall_bad[gi] = 0;
                    lv_cnt[gi]    = 0;
                    fwv_cnt[gi]   = 0;
                    fwv_edge[gi]  = -1;
                    frsp_edge[gi] = -1;
                end else if (busy[gi] === 1'b1) begin
                    if (bus_req_valid[gi] === 1'b1 && bus_req_ready[gi] === 1'b1) begin
                        if (iss_seen[gi] == 0) first_addr[gi] = bus_req_addr[gi];
                        if (bus_req_addr[gi] !== exp_base[gi] + 32'(((exp_start[gi] + iss_seen[gi]) % NB) * 4))
                            addr_bad[gi]++;
                        iss_seen[gi]++;
                    end
                    if (bus_rsp_valid[gi] === 1'b1) begin
                        if (rsp_seen[gi] == 0) frsp_edge[gi] = e_l;
                        rsp_seen[gi]++;
                    end
                    if (iss_seen[gi] - rsp_seen[gi] > max_out[gi]) max_out[gi] = iss_seen[gi] - rsp_seen[gi];
                    if (prev_stall && (bus_req_valid[gi] !== 1'b1 || bus_req_addr[gi] !== prev_addr))
                        stall_bad[gi]++;
                end
                if (line_valid[gi] === 1'b1) begin
                    lv_cnt[gi]++;
                    lv_total[gi]++;
                    lv_edge[gi] = e_l;
                    lv_line[gi] = line_data[gi];
                end
`ifdef ICACHE_FILL_WRAP_EN
                if (first_word_valid[gi] === 1'b1) begin
                    fwv_cnt[gi]++;
                    fwv_edge[gi] = e_l;
                end
`endif
            end
            prev_stall = (bus_req_valid[gi] === 1'b1) && (bus_req_ready[gi] !== 1'b1);
            prev_addr  = bus_req_addr[gi];
        end

        // Memory response and ready driver for the coming edge.
        always @(negedge clk) begin
            if (due_q.size() > 0 && due_q[0] <= cyc + 1) begin
                bus_rsp_valid[gi] = 1'b1;
                bus_rsp_data[gi]  = dat_q[0];
            end else begin
                bus_rsp_valid[gi] = 1'b0;
                bus_rsp_data[gi]  = $urandom;
            end
            case (ready_mode[gi])
                1:       bus_req_ready[gi] = ($urandom_range(0, 3) != 0);
                2:       bus_req_ready[gi] = (cyc + 1 > stall_until[gi]);
                default: bus_req_ready[gi] = 1'b1;
            endcase
        end
    end

    // Runs one fill on instance idx and checks it against the line model.
    task automatic do_fill(input int idx, input logic [31:0] addr, input int lat,
                           input int mode, input int stall, input bit hold_req, input string name);
        int           acc0, lv0, start, mx, lat_exp;
        bit           ok;
        logic [31:0]  base;
        logic [511:0] exp_line;
        @(negedge clk);
        lat_a[idx]       = lat;
        ready_mode[idx]  = mode;
        stall_until[idx] = cyc + 1 + stall;
        fill_req[idx]    = 1'b1;
        fill_addr[idx]   = addr;
        acc0 = acc_total[idx];
        lv0  = lv_total[idx];
        ok   = 1'b0;
        for (int k = 0; k < 5 && !ok; k++) begin
            @(negedge clk);
            if (acc_total[idx] != acc0) ok = 1'b1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s accept: accepted=0 required=1", name);
            fill_req[idx] = 1'b0;
            return;
        end
        if (!hold_req) fill_req[idx] = 1'b0;
        fill_addr[idx] = $urandom;
        ok = 1'b0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge clk);
            if (lv_total[idx] != lv0) ok = 1'b1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s line_valid timeout: pulses=0 required=1", name);
            fill_req[idx] = 1'b0;
            return;
        end
        base = addr & LMASK;
`ifdef ICACHE_FILL_WRAP_EN
        start = int'(addr[5:2]);
`else
        start = 0;
`endif
        for (int w = 0; w < NB; w++) exp_line[w*32 +: 32] = (base + 32'(w * 4)) ^ XMASK;
        mx      = (idx == 0) ? 4 : 1;
        lat_exp = (idx == 0) ? 18 : 33;
        total++;
        if (lv_line[idx] !== exp_line) begin
            bad++;
            $display("FAIL %s line: got=%h want=%h", name, lv_line[idx], exp_line);
        end
        total++;
        if (addr_bad[idx] != 0 || iss_seen[idx] != NB || rsp_seen[idx] != NB) begin
            bad++;
            $display("FAIL %s bus order: addr_errors=%0d issued=%0d responses=%0d required 0/16/16",
                     name, addr_bad[idx], iss_seen[idx], rsp_seen[idx]);
        end
        total++;
        if (first_addr[idx] !== base + 32'(start * 4)) begin
            bad++;
            $display("FAIL %s first addr: got=%h want=%h", name, first_addr[idx], base + 32'(start * 4));
        end
        total++;
        if (stall_bad[idx] != 0 || max_out[idx] > mx) begin
            bad++;
            $display("FAIL %s stall/outstanding: unstable=%0d max_out=%0d required 0 and <=%0d",
                     name, stall_bad[idx], max_out[idx], mx);
        end
        if (lat == 1 && mode == 0) begin
            total++;
            if (lv_edge[idx] - acc_edge[idx] != lat_exp) begin
                bad++;
                $display("FAIL %s latency: got=%0d want=%0d", name, lv_edge[idx] - acc_edge[idx], lat_exp);
            end
        end
        if (!hold_req) begin
            repeat (2) @(negedge clk);
            total++;
            if (lv_cnt[idx] != 1 || busy[idx] !== 1'b0 || line_data[idx] !== exp_line) begin
                bad++;
                $display("FAIL %s after fill: pulses=%0d busy=%b held=%0d required 1/0/1",
                         name, lv_cnt[idx], busy[idx], line_data[idx] === exp_line);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (line_valid[i] !== 1'b0 || bus_req_valid[i] !== 1'b0 || bus_req_addr[i] !== 32'h0 ||
                line_data[i] !== 512'h0 || busy[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset dut%0d: lv=%b rv=%b addr=%h busy=%b data_zero=%0d required all 0",
                         i, line_valid[i], bus_req_valid[i], bus_req_addr[i], busy[i], line_data[i] === 512'h0);
            end
`ifdef ICACHE_FILL_WRAP_EN
            total++;
            if (first_word_valid[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset dut%0d first_word_valid: got=%b want=0", i, first_word_valid[i]);
            end
`endif
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_fill(0, 32'h0000_1040, 1, 0, 0, 1'b0, "basic");
    endtask

    task automatic test_backpressure();
        do_fill(0, 32'h0000_5A00, 10, 2, 5, 1'b0, "backpressure");
        do_fill(0, $urandom, 7, 1, 0, 1'b0, "random_ready");
    endtask

    task automatic test_rearm();
        int  acc0;
        int  rv_hi;
        int  busy_lo;
        do_fill(0, $urandom, 1, 0, 0, 1'b1, "rearm_first");
        acc0    = acc_total[0];
        rv_hi   = 0;
        busy_lo = 0;
        for (int k = 0; k < 3; k++) begin
            if (bus_req_valid[0] !== 1'b0) rv_hi++;
            if (busy[0] !== 1'b1) busy_lo++;
            @(negedge clk);
        end
        total++;
        if (rv_hi != 0 || busy_lo != 0 || acc_total[0] != acc0) begin
            bad++;
            $display("FAIL rearm hold: req_cycles=%0d idle_cycles=%0d new_fills=%0d required 0/0/0",
                     rv_hi, busy_lo, acc_total[0] - acc0);
        end
        fill_req[0] = 1'b0;
        @(negedge clk);
        do_fill(0, $urandom, 2, 0, 0, 1'b0, "rearm_second");
    endtask

    task automatic test_reset_mid_fill();
        int lv0;
        bit ok;
        @(negedge clk);
        lat_a[0]      = 3;
        ready_mode[0] = 0;
        fill_req[0]   = 1'b1;
        fill_addr[0]  = $urandom;
        @(negedge clk);
        fill_req[0]   = 1'b0;
        lv0 = lv_total[0];
        ok  = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (rsp_seen[0] >= 7) ok = 1'b1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL midreset progress: responses=%0d required>=7", rsp_seen[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (line_valid[0] !== 1'b0 || bus_req_valid[0] !== 1'b0 || bus_req_addr[0] !== 32'h0 ||
            line_data[0] !== 512'h0 || busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL midreset values: lv=%b rv=%b addr=%h busy=%b required 0", line_valid[0],
                     bus_req_valid[0], bus_req_addr[0], busy[0]);
        end
        repeat (20) @(negedge clk);
        total++;
        if (lv_total[0] != lv0 || line_data[0] !== 512'h0 || busy[0] !== 1'b0 || bus_req_valid[0] !== 1'b0) begin
            bad++;
            $display("FAIL midreset late responses: pulses=%0d data_zero=%0d busy=%b rv=%b required 0/1/0/0",
                     lv_total[0] - lv0, line_data[0] === 512'h0, busy[0], bus_req_valid[0]);
        end
        do_fill(0, 32'h0000_2000, 1, 0, 0, 1'b0, "post_reset");
    endtask

    task automatic test_max_outstanding_one();
        do_fill(1, $urandom, 1, 0, 0, 1'b0, "max1_alternate");
        do_fill(1, $urandom, 4, 1, 0, 1'b0, "max1_random");
    endtask

    task automatic test_back_to_back();
        do_fill(0, 32'h0000_7FC4, 1, 0, 0, 1'b0, "b2b_a");
        do_fill(0, 32'h0000_7FF8, 1, 0, 0, 1'b0, "b2b_b");
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            do_fill($urandom_range(0, 1), $urandom, $urandom_range(1, 10), $urandom_range(0, 1), 0,
                    1'b0, "random");
        end
    endtask

`ifdef ICACHE_FILL_WRAP_EN
    task automatic test_wrap();
        do_fill(0, 32'h0000_3038, 1, 0, 0, 1'b0, "wrap");
        total++;
        if (fwv_cnt[0] != 1 || fwv_edge[0] != frsp_edge[0] + 1) begin
            bad++;
            $display("FAIL wrap first_word_valid: pulses=%0d edge=%0d required 1 at %0d",
                     fwv_cnt[0], fwv_edge[0], frsp_edge[0] + 1);
        end
        total++;
        if (lv_line[0][14*32 +: 32] !== (32'h0000_3038 ^ XMASK)) begin
            bad++;
            $display("FAIL wrap word14: got=%h want=%h", lv_line[0][14*32 +: 32], 32'h0000_3038 ^ XMASK);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            fill_req[i]    = 1'b0;
            fill_addr[i]   = 32'h0;
            lat_a[i]       = 1;
            ready_mode[i]  = 0;
            stall_until[i] = 0;
        end
        test_reset();
        test_basic();
        test_backpressure();
        test_rearm();
        test_reset_mid_fill();
        test_max_outstanding_one();
        test_back_to_back();
`ifdef ICACHE_FILL_WRAP_EN
        test_wrap();
`endif
        test_random();
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
